// File: rtl/bc_mem_xfer.sv
// Bus-connect transfer engine: moves data between the RF crossbar and data memory
// (loads, immediate loads, stores) with a bounded req/ack wait and registered outputs.
module bc_mem_xfer #(
  parameter int RF_DATASIZE    = 16,
  parameter int DM_ADDR_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps_bc_en,
  input  logic                     ps_bc_dir,
  input  logic                     ps_bc_imm_en,
  input  logic [RF_DATASIZE-1:0]   ps_bc_imm,
  input  logic [DM_ADDR_WIDTH-1:0] ps_bc_addr,
  input  logic [RF_DATASIZE-1:0]   xb_dtx,
  output logic [RF_DATASIZE-1:0]   bc_dt,
  output logic                     bc_rf_wen,
  output logic                     bc_ps_busy,
  output logic                     bc_ps_done,
  output logic                     bc_ps_err,
  output logic                     bc_dm_req,
  output logic                     bc_dm_we,
  output logic [DM_ADDR_WIDTH-1:0] bc_dm_addr,
  output logic [RF_DATASIZE-1:0]   bc_dm_wdata,
  input  logic                     dm_bc_ack,
  input  logic [RF_DATASIZE-1:0]   dm_bc_rdata
);

  // state | meaning
  // IDLE  | waiting for ps_bc_en; done/err of a store or timeout may be showing
  // REQ   | bc_dm_req held, waiting for dm_bc_ack or the timeout count
  // WB    | bc_dt valid, bc_rf_wen and bc_ps_done high for this one cycle
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [RF_DATASIZE-1:0]   dt_n, wdata_n;
  logic [DM_ADDR_WIDTH-1:0] addr_n;
  logic                     wen_n, done_n, err_n, req_n, we_n, busy_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bc_dt       <= '0;
      bc_rf_wen   <= 1'b0;
      bc_ps_busy  <= 1'b0;
      bc_ps_done  <= 1'b0;
      bc_ps_err   <= 1'b0;
      bc_dm_req   <= 1'b0;
      bc_dm_we    <= 1'b0;
      bc_dm_addr  <= '0;
      bc_dm_wdata <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bc_dt       <= dt_n;
      bc_rf_wen   <= wen_n;
      bc_ps_busy  <= busy_n;
      bc_ps_done  <= done_n;
      bc_ps_err   <= err_n;
      bc_dm_req   <= req_n;
      bc_dm_we    <= we_n;
      bc_dm_addr  <= addr_n;
      bc_dm_wdata <= wdata_n;
    end
  end

  // Every output is computed for the next cycle and registered above.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dt_n    = bc_dt;
    wen_n   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    req_n   = 1'b0;
    we_n    = bc_dm_we;
    addr_n  = bc_dm_addr;
    wdata_n = bc_dm_wdata;
    case (state)
      IDLE: begin
        if (ps_bc_en) begin
          we_n   = ps_bc_dir;
          addr_n = ps_bc_addr;
          if (ps_bc_dir) wdata_n = xb_dtx;
          if (!ps_bc_dir && ps_bc_imm_en) begin
            dt_n    = ps_bc_imm;
            wen_n   = 1'b1;
            done_n  = 1'b1;
            state_n = WB;
          end else begin
            cnt_n   = '0;
            req_n   = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        // bc_dm_we still holds the direction latched at accept
        if (dm_bc_ack) begin
          done_n = 1'b1;
          if (!bc_dm_we) begin
            dt_n    = dm_bc_rdata;
            wen_n   = 1'b1;
            state_n = WB;
          end else begin
            state_n = IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
          req_n = 1'b1;
        end
      end
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule
